// File: rtl/vx_operand_collector.sv
// vx_operand_collector: banked GPR file that gathers all source operands of one instruction per request
module vx_operand_collector #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 32,
    parameter int NUM_WIS     = 4,
    parameter int NUM_SRCS    = 3,
    parameter int NUM_BANKS   = 2,
    parameter int META_W      = 64,
    parameter int NRW         = $clog2(NUM_REGS),
    parameter int WISW        = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WISW-1:0]                    in_wis,
    input  logic [NUM_SRCS*NRW-1:0]            in_rs,
    input  logic [META_W-1:0]                  in_meta,
    input  logic                               wb_valid,
    input  logic [WISW-1:0]                    wb_wis,
    input  logic [NRW-1:0]                     wb_rd,
    input  logic [NUM_THREADS-1:0]             wb_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]        wb_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WISW-1:0]                    out_wis,
    output logic [META_W-1:0]                  out_meta,
    output logic [NUM_SRCS*NUM_THREADS*XLEN-1:0] out_data
);
    localparam int RPB   = NUM_REGS / NUM_BANKS;
    localparam int DEPTH = NUM_WIS * RPB;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BSW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, OUT = 2'd3;

    function automatic logic [BSW-1:0] bank(input logic [NRW-1:0] r);
        return BSW'(int'(r) % NUM_BANKS);
    endfunction

    function automatic logic [AW-1:0] addr(input logic [WISW-1:0] w, input logic [NRW-1:0] r);
        return AW'(int'(w) * RPB + int'(r) / NUM_BANKS);
    endfunction

    logic [1:0]          state, nxt;
    logic [NUM_SRCS-1:0] pending, grant, g_q, nz;
    logic [WISW-1:0]     wis_q;
    logic [NRW-1:0]      rs_q [NUM_SRCS];
    logic [META_W-1:0]   meta_q;
    logic [NRW-1:0]      sel_rs [NUM_BANKS];
    logic [NUM_BANKS-1:0] found;
    logic [XLEN-1:0]     mem [NUM_BANKS][NUM_THREADS][DEPTH];
    logic [XLEN-1:0]     rdata [NUM_BANKS][NUM_THREADS];
    logic                acc;

    assign in_ready  = state == IDLE;
    assign out_valid = state == OUT;
    assign out_wis   = wis_q;
    assign out_meta  = meta_q;
    assign acc       = in_valid && in_ready;

    // Each bank serves its lowest pending source; duplicates of that register ride along
    always_comb begin
        for (int k = 0; k < NUM_SRCS; k++)
            nz[k] = in_rs[k*NRW +: NRW] != '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            found[b]  = 1'b0;
            sel_rs[b] = '0;
            for (int k = NUM_SRCS - 1; k >= 0; k--)
                if (pending[k] && bank(rs_q[k]) == BSW'(b)) begin
                    found[b]  = 1'b1;
                    sel_rs[b] = rs_q[k];
                end
        end
        for (int k = 0; k < NUM_SRCS; k++)
            grant[k] = pending[k] && rs_q[k] == sel_rs[bank(rs_q[k])];
        nxt = (state == IDLE)  ? (acc ? ((|nz) ? FETCH : OUT) : IDLE) :
              (state == FETCH) ? ((|(pending & ~grant)) ? FETCH : DRAIN) :
              (state == DRAIN) ? OUT :
              (out_ready ? IDLE : OUT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
            g_q     <= '0;
        end else begin
            state   <= nxt;
            g_q     <= (state == FETCH) ? grant : '0;
            pending <= acc ? nz : (state == FETCH) ? (pending & ~grant) : pending;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            wis_q  <= in_wis;
            meta_q <= in_meta;
            for (int k = 0; k < NUM_SRCS; k++)
                rs_q[k] <= in_rs[k*NRW +: NRW];
        end
    end

    // Write-first read port: a same-cycle writeback to the read address is returned directly
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++)
            for (int j = 0; j < NUM_THREADS; j++) begin
                if (wb_valid && wb_tmask[j] && bank(wb_rd) == BSW'(b))
                    mem[b][j][addr(wb_wis, wb_rd)] <= wb_data[j*XLEN +: XLEN];
                if (state == FETCH && found[b])
                    rdata[b][j] <= (wb_valid && wb_tmask[j] && bank(wb_rd) == BSW'(b) &&
                                    addr(wb_wis, wb_rd) == addr(wis_q, sel_rs[b]))
                                   ? wb_data[j*XLEN +: XLEN] : mem[b][j][addr(wis_q, sel_rs[b])];
            end
    end

    always_ff @(posedge clk) begin
        if (acc)
            out_data <= '0;
        else
            for (int k = 0; k < NUM_SRCS; k++)
                for (int j = 0; j < NUM_THREADS; j++)
                    if (g_q[k])
                        out_data[(k*NUM_THREADS+j)*XLEN +: XLEN] <=
                            (wb_valid && wb_tmask[j] && wb_wis == wis_q && wb_rd == rs_q[k])
                            ? wb_data[j*XLEN +: XLEN] : rdata[bank(rs_q[k])][j];
    end
endmodule

// File: tb/tb_vx_operand_collector.sv
// tb_vx_operand_collector: directed checks of latency, bank conflicts, forwarding, backpressure and reset
module tb_vx_operand_collector;
    logic         clk = 0;
    logic         reset = 0;
    logic         in_valid = 0, in_ready;
    logic [1:0]   in_wis = 0;
    logic [14:0]  in_rs = 0;
    logic [63:0]  in_meta = 0;
    logic         wb_valid = 0;
    logic [1:0]   wb_wis = 0;
    logic [4:0]   wb_rd = 0;
    logic [3:0]   wb_tmask = 0;
    logic [127:0] wb_data = 0;
    logic         out_valid, out_ready = 0;
    logic [1:0]   out_wis;
    logic [63:0]  out_meta;
    logic [383:0] out_data;
    int           n_chk = 0, n_fail = 0, lat;
    logic [383:0] exp_d;

    vx_operand_collector dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_wis(in_wis), .in_rs(in_rs), .in_meta(in_meta),
        .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_wis(out_wis), .out_meta(out_meta),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rep(input logic [31:0] v);
        return {4{v}};
    endfunction

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] w, input logic [4:0] r, input logic [3:0] m, input logic [31:0] d);
        @(negedge clk);
        wb_valid = 1; wb_wis = w; wb_rd = r; wb_tmask = m; wb_data = rep(d);
        @(negedge clk);
        wb_valid = 0;
    endtask

    // d selects the cycle after accept (1 = first FETCH) in which a writeback is driven; 0 = none
    task automatic issue(input logic [1:0] w, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [63:0] m, input int d, input logic [4:0] fr, input logic [3:0] fm,
                         input logic [31:0] fd, output int l);
        @(negedge clk);
        in_valid = 1; in_wis = w; in_rs = {r2, r1, r0}; in_meta = m;
        @(negedge clk);
        in_valid = 0; l = 1;
        while (!out_valid && l < 20) begin
            wb_valid = (l == d); wb_wis = w; wb_rd = fr; wb_tmask = fm; wb_data = rep(fd);
            @(negedge clk);
            l++;
        end
        wb_valid = 0;
    endtask

    task automatic release_out;
        @(negedge clk);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1;
        chk("reset_out_valid", 384'(out_valid), 384'(0));
        chk("reset_in_ready", 384'(in_ready), 384'(1));
        wr(0, 5, 4'hf, 32'h11);
        wr(0, 6, 4'hf, 32'h22);
        wr(0, 7, 4'hf, 32'h33);
        wr(0, 9, 4'hf, 32'hAB);
        wr(1, 5, 4'hf, 32'hCC);

        issue(0, 5, 6, 7, 64'hA1, 0, 0, 0, 0, lat);
        chk("conflict_lat", 384'(lat), 384'(4));
        chk("conflict_data", out_data, {rep(32'h33), rep(32'h22), rep(32'h11)});
        chk("conflict_meta", 384'(out_meta), 384'(64'hA1));
        chk("conflict_wis", 384'(out_wis), 384'(0));
        chk("conflict_in_ready", 384'(in_ready), 384'(0));
        release_out;
        chk("release_in_ready", 384'(in_ready), 384'(1));
        chk("release_out_valid", 384'(out_valid), 384'(0));

        issue(0, 0, 0, 0, 64'hB2, 0, 0, 0, 0, lat);
        chk("zero_lat", 384'(lat), 384'(1));
        chk("zero_data", out_data, 384'(0));
        chk("zero_meta", 384'(out_meta), 384'(64'hB2));
        release_out;

        issue(0, 9, 9, 9, 64'hC3, 0, 0, 0, 0, lat);
        chk("dup_lat", 384'(lat), 384'(3));
        chk("dup_data", out_data, {rep(32'hAB), rep(32'hAB), rep(32'hAB)});
        release_out;

        issue(1, 5, 5, 0, 64'hD4, 0, 0, 0, 0, lat);
        chk("wis1_lat", 384'(lat), 384'(3));
        chk("wis1_data", out_data, {128'h0, rep(32'hCC), rep(32'hCC)});
        chk("wis1_wis", 384'(out_wis), 384'(1));
        release_out;

        issue(0, 6, 0, 0, 64'hE5, 1, 6, 4'b0101, 32'h55, lat);
        chk("fwd_issue_lat", 384'(lat), 384'(3));
        chk("fwd_issue_data", out_data, {256'h0, 32'h22, 32'h55, 32'h22, 32'h55});
        release_out;

        issue(0, 7, 0, 0, 64'hF6, 2, 7, 4'b1000, 32'h77, lat);
        chk("fwd_capture_lat", 384'(lat), 384'(3));
        chk("fwd_capture_data", out_data, {256'h0, 32'h77, 32'h33, 32'h33, 32'h33});
        release_out;

        issue(0, 5, 9, 5, 64'h1234, 0, 0, 0, 0, lat);
        exp_d = {rep(32'h11), rep(32'hAB), rep(32'h11)};
        chk("bp_lat", 384'(lat), 384'(4));
        in_valid = 1; in_wis = 2; in_rs = 0; in_meta = 64'h5678;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 384'(out_valid), 384'(1));
            chk("bp_data", out_data, exp_d);
            chk("bp_meta", 384'(out_meta), 384'(64'h1234));
            chk("bp_in_ready", 384'(in_ready), 384'(0));
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("bp_exit_in_ready", 384'(in_ready), 384'(1));
        chk("bp_exit_out_valid", 384'(out_valid), 384'(0));
        @(negedge clk);
        in_valid = 0;
        chk("bp_next_out_valid", 384'(out_valid), 384'(1));
        chk("bp_next_meta", 384'(out_meta), 384'(64'h5678));
        chk("bp_next_wis", 384'(out_wis), 384'(2));
        chk("bp_next_data", out_data, 384'(0));
        release_out;

        @(negedge clk);
        in_valid = 1; in_wis = 0; in_rs = {5'd0, 5'd7, 5'd5}; in_meta = 64'h99;
        @(negedge clk);
        in_valid = 0; reset = 0;
        @(negedge clk);
        reset = 1;
        chk("midreset_out_valid", 384'(out_valid), 384'(0));
        chk("midreset_in_ready", 384'(in_ready), 384'(1));
        repeat (5) @(negedge clk);
        chk("midreset_abandoned", 384'(out_valid), 384'(0));
        issue(0, 5, 0, 0, 64'hAA, 0, 0, 0, 0, lat);
        chk("reread_lat", 384'(lat), 384'(3));
        chk("reread_data", out_data, {256'h0, rep(32'h11)});
        release_out;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
